writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port RegWriteW, input, 1 bit: W-stage register write enable.
REQ-004 SHALL have port ResSrcW, input, 2 bits: result select; 00 = ALU result, 01 = memory read data, 10 = PC+4, 11 = extended immediate.
REQ-005 SHALL have port JalrW, input, 1 bit: W-stage jalr indicator; forces the link value.
REQ-006 SHALL have port RdW, input, 5 bits: destination register index.
REQ-007 SHALL have ports ALUResultW, ReadDataW, PCPlus4W and ExtImmW, input, 32 bits each: the result candidates.
REQ-008 SHALL have ports Rs1D and Rs2D, input, 5 bits each: D-stage read indices.
REQ-009 SHALL have ports RD1D and RD2D, output, 32 bits each: D-stage read data.
REQ-010 SHALL have port ResultW, output, 32 bits: the selected writeback value, for forwarding.
REQ-011 SHALL have port RetireCnt, output, 32 bits: count of committed register writes.

Function
REQ-012 ResultW SHALL be combinational:
- JalrW=1: PCPlus4W, regardless of ResSrcW.
- Otherwise: the candidate selected by ResSrcW per REQ-004.
REQ-013 Storage SHALL be 31 general registers x1..x31, 32 bits each.
REQ-014 x0 SHALL always read 0; writes with RdW=0 SHALL be discarded.
REQ-015 On a rising edge with Rst=0, RegWriteW=1 and RdW!=0, register[RdW] SHALL load ResultW.
REQ-016 RD1D SHALL be combinational, evaluated in this order:
- Rs1D=0: 0.
- RegWriteW=1 and RdW=Rs1D: ResultW (write-through bypass, same cycle).
- Otherwise: register[Rs1D].
REQ-017 RD2D SHALL follow the REQ-016 rules using Rs2D.
REQ-018 Both read ports SHALL operate independently; Rs1D=Rs2D=RdW SHALL bypass on both ports at once.
REQ-019 RetireCnt SHALL increment by 1 on each rising edge where a write per REQ-015 commits.
REQ-020 Writes to x0 and cycles with RegWriteW=0 SHALL NOT increment RetireCnt.
REQ-021 RetireCnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-022 The block SHALL hold the register image indefinitely while RegWriteW=0; it SHALL have no other state and no stall input.
REQ-023 Unknown (X) on ResSrcW with RegWriteW=0 SHALL NOT corrupt any register.

Reset
REQ-024 On a rising edge with Rst=1, registers x1..x31 and RetireCnt SHALL clear to 0.
REQ-025 Reset SHALL take priority over a simultaneous write; that write is lost and not counted.
REQ-026 Rst SHALL NOT gate the read bypass: during reset, RD1D and RD2D still follow REQ-016/017 combinationally.
REQ-027 After Rst deasserts, the first write SHALL commit on the next qualifying edge with no extra latency.

Verification
REQ-028 Reset, then read all 32 indices -> every RD1D/RD2D = 0 and RetireCnt = 0.
REQ-029 RegWriteW=1, RdW=5, ResSrcW=00, ALUResultW=0x1234_5678, Rs1D=5 in the same cycle -> RD1D = 0x12345678 before the edge (bypass); after the edge, with RegWriteW=0, RD1D still = 0x12345678; RetireCnt = 1.
REQ-030 RegWriteW=1, RdW=0, ALUResultW=0xDEADBEEF -> RD1D with Rs1D=0 = 0 both before and after the edge; RetireCnt unchanged.
REQ-031 JalrW=1, ResSrcW=01, PCPlus4W=0x0000_0104, ReadDataW=0xAAAA_AAAA, RdW=1 -> ResultW = 0x104 and x1 = 0x104 after the edge.
REQ-032 Rst=1 together with RegWriteW=1, RdW=7 after x7 was written 0x55 -> x7 = 0 after the edge and RetireCnt = 0.
REQ-033 Force RetireCnt to 0xFFFFFFFF via 2^32-1 writes (or a backdoor), then one write to x3 -> RetireCnt = 0 and x3 updated.

Source files
------------

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Purpose  : W-stage result select, 31x32 register file with write-through
//            bypass to both D-stage read ports, and a retired-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWriteW,
    input  logic [1:0]  ResSrcW,
    input  logic        JalrW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] PCPlus4W,
    input  logic [31:0] ExtImmW,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ResultW,
    output logic [31:0] RetireCnt
);

    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_MEM = 2'b01;
    localparam logic [1:0] c_SRC_PC4 = 2'b10;
    localparam logic [1:0] c_SRC_IMM = 2'b11;

    logic [31:0] w_result;
    logic        w_commit;
    logic [31:0] w_rf [0:31];
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // A jalr always links, whatever the result select says.
    always_comb begin
        w_result = ALUResultW;
        if (JalrW) begin
            w_result = PCPlus4W;
        end else begin
            case (ResSrcW)
                c_SRC_ALU: w_result = ALUResultW;
                c_SRC_MEM: w_result = ReadDataW;
                c_SRC_PC4: w_result = PCPlus4W;
                c_SRC_IMM: w_result = ExtImmW;
                default:   w_result = ALUResultW;
            endcase
        end
    end

    assign ResultW  = w_result;
    assign w_commit = RegWriteW && (RdW != 5'd0);

    assign w_rf[0] = 32'd0;

    generate
        for (genvar i = 1; i < 32; i++) begin : g_reg
            logic [31:0] reg_q;
            logic [31:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (w_commit && (RdW == 5'(i))) begin
                    reg_d = w_result;
                end
            end

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    reg_q <= 32'd0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign w_rf[i] = reg_q;
        end
    endgenerate

    // Bypass deliberately ignores Rst so decode sees the in-flight result.
    function automatic logic [31:0] read_port(
        input logic [4:0]  idx,
        input logic        we,
        input logic [4:0]  rd,
        input logic [31:0] res,
        input logic [31:0] stored
    );
        logic [31:0] val;
        if (idx == 5'd0) begin
            val = 32'd0;
        end else if (we && (rd == idx)) begin
            val = res;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign RD1D = read_port(Rs1D, RegWriteW, RdW, w_result, w_rf[Rs1D]);
    assign RD2D = read_port(Rs2D, RegWriteW, RdW, w_result, w_rf[Rs2D]);

    always_comb begin
        cnt_d = cnt_q;
        if (w_commit) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign RetireCnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Directed self-checking bench for writeback_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RegWriteW;
    logic [1:0]  ResSrcW;
    logic        JalrW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ExtImmW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] RetireCnt;

    int errors = 0;
    int checks = 0;

    writeback_regfile dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .RegWriteW  (RegWriteW),
        .ResSrcW    (ResSrcW),
        .JalrW      (JalrW),
        .RdW        (RdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .ExtImmW    (ExtImmW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .RetireCnt  (RetireCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RegWriteW  = 1'b0;
        JalrW      = 1'b0;
        ResSrcW    = 2'b00;
        RdW        = 5'd0;
        ALUResultW = 32'd0;
        ReadDataW  = 32'd0;
        PCPlus4W   = 32'd0;
        ExtImmW    = 32'd0;
    endtask

    // Write via the ALU path and retire it on the next edge.
    task automatic wr(input logic [4:0] rd, input logic [31:0] val);
        @(negedge Clk);
        idle();
        RegWriteW  = 1'b1;
        RdW        = rd;
        ALUResultW = val;
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        Rs1D = idx;
        Rs2D = idx;
        #1;
        check({tag, ".rd1"}, RD1D, exp);
        check({tag, ".rd2"}, RD2D, exp);
    endtask

    initial begin
        idle();
        Rst  = 1'b1;
        Rs1D = 5'd0;
        Rs2D = 5'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        // Post-reset image is all zero
        for (int i = 0; i < 32; i++) begin
            Rs1D = 5'(i);
            Rs2D = 5'(31 - i);
            #1;
            check($sformatf("reset.rd1[%0d]", i), RD1D, 32'd0);
            check($sformatf("reset.rd2[%0d]", 31 - i), RD2D, 32'd0);
        end
        check("reset.cnt", RetireCnt, 32'd0);

        // Same-cycle bypass, then stored value
        @(negedge Clk);
        RegWriteW  = 1'b1;
        RdW        = 5'd5;
        ResSrcW    = 2'b00;
        ALUResultW = 32'h1234_5678;
        Rs1D       = 5'd5;
        Rs2D       = 5'd6;
        #1;
        check("byp.rd1", RD1D, 32'h1234_5678);
        check("byp.rd2_other", RD2D, 32'd0);
        @(posedge Clk);
        #1;
        idle();
        #1;
        check("x5.stored", RD1D, 32'h1234_5678);
        check("x5.cnt", RetireCnt, 32'd1);

        // x0 write is discarded and not counted
        @(negedge Clk);
        RegWriteW  = 1'b1;
        RdW        = 5'd0;
        ALUResultW = 32'hDEAD_BEEF;
        Rs1D       = 5'd0;
        #1;
        check("x0.pre", RD1D, 32'd0);
        @(posedge Clk);
        #1;
        check("x0.post", RD1D, 32'd0);
        check("x0.cnt", RetireCnt, 32'd1);
        idle();

        // jalr overrides ResSrcW
        @(negedge Clk);
        RegWriteW = 1'b1;
        JalrW     = 1'b1;
        ResSrcW   = 2'b01;
        PCPlus4W  = 32'h0000_0104;
        ReadDataW = 32'hAAAA_AAAA;
        RdW       = 5'd1;
        #1;
        check("jalr.result", ResultW, 32'h0000_0104);
        @(posedge Clk);
        #1;
        idle();
        rd_chk("jalr.x1", 5'd1, 32'h0000_0104);
        check("jalr.cnt", RetireCnt, 32'd2);

        // Each result source, written to distinct registers
        @(negedge Clk);
        RegWriteW = 1'b1;
        ALUResultW = 32'h1111_1111;
        ReadDataW  = 32'h2222_2222;
        PCPlus4W   = 32'h3333_3333;
        ExtImmW    = 32'h4444_4444;
        ResSrcW = 2'b01; RdW = 5'd2; #1;
        check("src01.result", ResultW, 32'h2222_2222);
        @(posedge Clk); #1;
        ResSrcW = 2'b10; RdW = 5'd4; #1;
        check("src10.result", ResultW, 32'h3333_3333);
        @(posedge Clk); #1;
        ResSrcW = 2'b11; RdW = 5'd31; #1;
        check("src11.result", ResultW, 32'h4444_4444);
        @(posedge Clk); #1;
        idle();
        rd_chk("x2", 5'd2, 32'h2222_2222);
        rd_chk("x4", 5'd4, 32'h3333_3333);
        rd_chk("x31", 5'd31, 32'h4444_4444);
        check("src.cnt", RetireCnt, 32'd5);

        // Both ports bypass simultaneously
        @(negedge Clk);
        Rs1D = 5'd9;
        Rs2D = 5'd9;
        #1;
        check("dual.pre_rd1", RD1D, 32'd0);
        RegWriteW  = 1'b1;
        RdW        = 5'd9;
        ALUResultW = 32'hCAFE_F00D;
        #1;
        check("dual.rd1", RD1D, 32'hCAFE_F00D);
        check("dual.rd2", RD2D, 32'hCAFE_F00D);
        @(posedge Clk);
        #1;
        idle();
        check("dual.cnt", RetireCnt, 32'd6);

        // Reset beats a concurrent write; bypass still live during reset
        wr(5'd7, 32'h0000_0055);
        rd_chk("x7.pre_rst", 5'd7, 32'h0000_0055);
        @(negedge Clk);
        Rst        = 1'b1;
        RegWriteW  = 1'b1;
        RdW        = 5'd7;
        ALUResultW = 32'h0000_0099;
        Rs1D       = 5'd7;
        Rs2D       = 5'd5;
        #1;
        check("rst.byp_rd1", RD1D, 32'h0000_0099);
        check("rst.rd2_x5", RD2D, 32'h1234_5678);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle();
        rd_chk("rst.x7", 5'd7, 32'd0);
        rd_chk("rst.x5", 5'd5, 32'd0);
        check("rst.cnt", RetireCnt, 32'd0);

        // First write after reset lands immediately
        wr(5'd8, 32'h0000_0011);
        rd_chk("post_rst.x8", 5'd8, 32'h0000_0011);
        check("post_rst.cnt", RetireCnt, 32'd1);

        // Counter wrap via backdoor preload
        @(negedge Clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap.preload", RetireCnt, 32'hFFFF_FFFF);
        wr(5'd3, 32'h0000_0033);
        check("wrap.cnt", RetireCnt, 32'd0);
        rd_chk("wrap.x3", 5'd3, 32'h0000_0033);

        // Image holds while writes are idle and sources churn
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            ResSrcW    = 2'(k);
            RdW        = 5'd3;
            ALUResultW = 32'hFFFF_0000 | 32'(k);
            ReadDataW  = 32'hEEEE_0000 | 32'(k);
            @(posedge Clk);
        end
        #1;
        idle();
        rd_chk("hold.x3", 5'd3, 32'h0000_0033);
        rd_chk("hold.x8", 5'd8, 32'h0000_0011);
        check("hold.cnt", RetireCnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
